// File: rtl/encode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : encode_scheduler
// Brief    : Round-robin grant of DFX words onto the encode_packet start/ready
//            handshake. Optional watchdog: ENCODE_SCHED_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module encode_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = 2,
  parameter int DATA_DFX_WIDTH = 1034,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*DATA_DFX_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic                              start_encode_pkt,
  output logic [DATA_DFX_WIDTH-1:0]         data_dfx_send,
  input  logic                              ready_encode_pkt,
  input  logic                              encode_done,
  output logic                              busy,
  output logic                              done_valid,
  output logic [ID_WIDTH-1:0]               done_id,
  output logic [15:0]                       pkt_count,
  output logic                              timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  localparam logic [ID_WIDTH-1:0] c_last_id = ID_WIDTH'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_WIDTH) < NUM_REQ || TIMEOUT_CYCLES < 2) begin : g_param_err
    $error("encode_scheduler: illegal parameter combination");
  end

  state_t                    r_state;
  logic [ID_WIDTH-1:0]       r_rr_ptr;
  logic [ID_WIDTH-1:0]       r_grant_id;
  logic                      w_found;
  logic [ID_WIDTH-1:0]       w_pick;
  logic [ID_WIDTH:0]         w_cand;
  logic [NUM_REQ-1:0]        w_pick_onehot;
  logic [ID_WIDTH-1:0]       w_next_ptr;
  logic [DATA_DFX_WIDTH-1:0] w_words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_words[g] = req_data[g*DATA_DFX_WIDTH +: DATA_DFX_WIDTH];
  end

  // Walk from the highest offset down so the closest set bit at/after rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(k);
      if (w_cand >= (ID_WIDTH+1)'(NUM_REQ)) begin
        w_cand = w_cand - (ID_WIDTH+1)'(NUM_REQ);
      end
      if (req_valid[w_cand[ID_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[ID_WIDTH-1:0];
      end
    end
  end

  assign w_pick_onehot = NUM_REQ'(1) << w_pick;
  assign w_next_ptr    = (r_grant_id == c_last_id) ? '0 : r_grant_id + 1'b1;

`ifdef ENCODE_SCHED_TIMEOUT_EN
  localparam logic [15:0] c_wd_limit = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wd_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_rr_ptr         <= '0;
      r_grant_id       <= '0;
      req_ack          <= '0;
      start_encode_pkt <= 1'b0;
      data_dfx_send    <= '0;
      busy             <= 1'b0;
      done_valid       <= 1'b0;
      done_id          <= '0;
      pkt_count        <= '0;
`ifdef ENCODE_SCHED_TIMEOUT_EN
      r_wd_cnt         <= '0;
      timeout_err      <= 1'b0;
`endif
    end else begin
      req_ack    <= '0;
      done_valid <= 1'b0;
`ifdef ENCODE_SCHED_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant_id       <= w_pick;
            data_dfx_send    <= w_words[w_pick];
            req_ack          <= w_pick_onehot;
            start_encode_pkt <= 1'b1;
            busy             <= 1'b1;
            r_state          <= S_START;
          end
        end
        S_START: begin
          if (start_encode_pkt && ready_encode_pkt) begin
            start_encode_pkt <= 1'b0;
            r_state          <= S_WAIT_DONE;
`ifdef ENCODE_SCHED_TIMEOUT_EN
            r_wd_cnt         <= '0;
`endif
          end
        end
        S_WAIT_DONE: begin
          if (encode_done) begin
            done_valid <= 1'b1;
            done_id    <= r_grant_id;
            pkt_count  <= pkt_count + 16'd1;
            r_rr_ptr   <= w_next_ptr;
            busy       <= 1'b0;
            r_state    <= S_IDLE;
          end
`ifdef ENCODE_SCHED_TIMEOUT_EN
          else if (r_wd_cnt == c_wd_limit) begin
            timeout_err <= 1'b1;
            r_rr_ptr    <= w_next_ptr;
            busy        <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
          end
`endif
        end
        default: begin
          start_encode_pkt <= 1'b0;
          busy             <= 1'b0;
          r_state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
